// File: rtl/ad9361_tdd_pkg.sv
// ============================================================================
// Module      : ad9361_tdd_pkg
// Description : Shared state encoding and default constants for the AD9361
//               TDD controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ad9361_tdd_pkg;

    localparam int c_DEF_CNT_WIDTH      = 24;
    localparam int c_DEF_SYNC_PULSE_LEN = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } tdd_state_t;

endpackage

`default_nettype wire

// File: rtl/ad9361_tdd_sync_det.sv
// ============================================================================
// Module      : ad9361_tdd_sync_det
// Description : Two-flop synchroniser for the external TDD sync input followed
//               by a registered rising-edge detector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ad9361_tdd_sync_det (
    input  logic clk,
    input  logic rst,
    input  logic i_sync,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_sync_d;
    logic r_rise;

    // The rise pulse is registered so the edge-to-RUN latency is three cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_sync_d <= 1'b0;
            r_rise   <= 1'b0;
        end else begin
            r_meta   <= i_sync;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
            r_rise   <= r_sync & ~r_sync_d;
        end
    end

    assign o_rise = r_rise;

endmodule

`default_nettype wire

// File: rtl/ad9361_tdd_ctrl.sv
// ============================================================================
// Module      : ad9361_tdd_ctrl
// Description : Frame-based TDD sequencer driving AD9361 ENABLE/TXNRX pins,
//               master or slave to an external sync. Optional sync pulse
//               output is built only with AD9361_TDD_SYNC_OUT_EN defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ad9361_tdd_ctrl
    import ad9361_tdd_pkg::*;
#(
    parameter int NUM_DEV        = 2,
    parameter int CNT_WIDTH      = c_DEF_CNT_WIDTH,
    parameter int SYNC_PULSE_LEN = c_DEF_SYNC_PULSE_LEN
) (
    input  logic                 axi_aclk,
    input  logic                 axi_areset,
    input  logic                 ctrl_en,
    input  logic                 ctrl_sync_ext,
    input  logic [NUM_DEV-1:0]   ctrl_dev_mask,
    input  logic [CNT_WIDTH-1:0] ctrl_frame_len,
    input  logic [CNT_WIDTH-1:0] ctrl_rx_on,
    input  logic [CNT_WIDTH-1:0] ctrl_rx_off,
    input  logic [CNT_WIDTH-1:0] ctrl_tx_on,
    input  logic [CNT_WIDTH-1:0] ctrl_tx_off,
    input  logic                 tdd_sync_i,
    output logic                 tdd_sync_o,
    output logic                 tdd_sync_t,
    output logic [NUM_DEV-1:0]   enable,
    output logic [NUM_DEV-1:0]   txnrx,
    output logic [CNT_WIDTH-1:0] frame_cnt,
    output logic                 busy
);

    tdd_state_t           r_state;
    logic [CNT_WIDTH-1:0] r_frame_cnt;
    logic [CNT_WIDTH-1:0] r_frame_len;
    logic [CNT_WIDTH-1:0] r_rx_on;
    logic [CNT_WIDTH-1:0] r_rx_off;
    logic [CNT_WIDTH-1:0] r_tx_on;
    logic [CNT_WIDTH-1:0] r_tx_off;
    logic                 r_sync_ext;
    logic [NUM_DEV-1:0]   r_mask;
    logic [NUM_DEV-1:0]   r_enable;
    logic [NUM_DEV-1:0]   r_txnrx;

    logic w_sync_rise;
    logic w_rx_act;
    logic w_tx_act;

    ad9361_tdd_sync_det u_sync_det (
        .clk    (axi_aclk),
        .rst    (axi_areset),
        .i_sync (tdd_sync_i),
        .o_rise (w_sync_rise)
    );

    // Windows do not wrap: on >= off yields an empty window.
    assign w_rx_act = (r_frame_cnt >= r_rx_on) && (r_frame_cnt < r_rx_off);
    assign w_tx_act = (r_frame_cnt >= r_tx_on) && (r_frame_cnt < r_tx_off);

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            r_state     <= ST_IDLE;
            r_frame_cnt <= '0;
            r_frame_len <= '0;
            r_rx_on     <= '0;
            r_rx_off    <= '0;
            r_tx_on     <= '0;
            r_tx_off    <= '0;
            r_sync_ext  <= 1'b0;
            r_mask      <= '0;
            r_enable    <= '0;
            r_txnrx     <= '0;
        end else if (!ctrl_en) begin
            r_state     <= ST_IDLE;
            r_frame_cnt <= '0;
            r_enable    <= '0;
            r_txnrx     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_frame_len <= ctrl_frame_len;
                    r_rx_on     <= ctrl_rx_on;
                    r_rx_off    <= ctrl_rx_off;
                    r_tx_on     <= ctrl_tx_on;
                    r_tx_off    <= ctrl_tx_off;
                    r_sync_ext  <= ctrl_sync_ext;
                    r_mask      <= ctrl_dev_mask;
                    r_frame_cnt <= '0;
                    r_enable    <= '0;
                    r_txnrx     <= '0;
                    r_state     <= ctrl_sync_ext ? ST_ARMED : ST_RUN;
                end
                ST_ARMED: begin
                    r_frame_cnt <= '0;
                    r_enable    <= '0;
                    r_txnrx     <= '0;
                    if (w_sync_rise) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (r_sync_ext && w_sync_rise) begin
                        r_frame_cnt <= '0;
                    end else if (r_frame_cnt == r_frame_len) begin
                        r_frame_cnt <= '0;
                    end else begin
                        r_frame_cnt <= r_frame_cnt + 1'b1;
                    end
                    r_enable <= r_mask & {NUM_DEV{w_rx_act | w_tx_act}};
                    r_txnrx  <= r_mask & {NUM_DEV{w_tx_act}};
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_frame_cnt <= '0;
                    r_enable    <= '0;
                    r_txnrx     <= '0;
                end
            endcase
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign enable    = r_enable;
    assign txnrx     = r_txnrx;
    assign busy      = (r_state != ST_IDLE);

`ifdef AD9361_TDD_SYNC_OUT_EN
    localparam logic [CNT_WIDTH-1:0] c_PULSE_LEN = CNT_WIDTH'(SYNC_PULSE_LEN);

    logic r_sync_o;

    // Pulse aligned with the enable/txnrx pipeline: high for the first
    // SYNC_PULSE_LEN counts of each frame.
    always_ff @(posedge axi_aclk) begin
        if (axi_areset || !ctrl_en) begin
            r_sync_o <= 1'b0;
        end else begin
            r_sync_o <= (r_state == ST_RUN) && !r_sync_ext &&
                        (r_frame_cnt < c_PULSE_LEN);
        end
    end

    assign tdd_sync_o = r_sync_o;
    assign tdd_sync_t = ~(busy & ~r_sync_ext);
`else
    assign tdd_sync_o = 1'b0;
    assign tdd_sync_t = 1'b1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ad9361_tdd_ctrl.sv
// ============================================================================
// Module      : tb_ad9361_tdd_ctrl
// Description : Self-checking bench for ad9361_tdd_ctrl (honours
//               AD9361_TDD_SYNC_OUT_EN when defined).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ad9361_tdd_ctrl;

    localparam int NUM_DEV   = 2;
    localparam int CNT_WIDTH = 24;
`ifdef AD9361_TDD_SYNC_OUT_EN
    localparam bit SYNC_EN = 1'b1;
`else
    localparam bit SYNC_EN = 1'b0;
`endif

    typedef struct packed {
        logic [NUM_DEV-1:0] en;
        logic [NUM_DEV-1:0] tx;
        logic               so;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 ctrl_en;
    logic                 ctrl_sync_ext;
    logic [NUM_DEV-1:0]   ctrl_dev_mask;
    logic [CNT_WIDTH-1:0] ctrl_frame_len;
    logic [CNT_WIDTH-1:0] ctrl_rx_on;
    logic [CNT_WIDTH-1:0] ctrl_rx_off;
    logic [CNT_WIDTH-1:0] ctrl_tx_on;
    logic [CNT_WIDTH-1:0] ctrl_tx_off;
    logic                 tdd_sync_i;
    logic                 tdd_sync_o;
    logic                 tdd_sync_t;
    logic [NUM_DEV-1:0]   enable;
    logic [NUM_DEV-1:0]   txnrx;
    logic [CNT_WIDTH-1:0] frame_cnt;
    logic                 busy;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    ad9361_tdd_ctrl #(
        .NUM_DEV        (NUM_DEV),
        .CNT_WIDTH      (CNT_WIDTH),
        .SYNC_PULSE_LEN (4)
    ) dut (
        .axi_aclk       (clk),
        .axi_areset     (rst),
        .ctrl_en        (ctrl_en),
        .ctrl_sync_ext  (ctrl_sync_ext),
        .ctrl_dev_mask  (ctrl_dev_mask),
        .ctrl_frame_len (ctrl_frame_len),
        .ctrl_rx_on     (ctrl_rx_on),
        .ctrl_rx_off    (ctrl_rx_off),
        .ctrl_tx_on     (ctrl_tx_on),
        .ctrl_tx_off    (ctrl_tx_off),
        .tdd_sync_i     (tdd_sync_i),
        .tdd_sync_o     (tdd_sync_o),
        .tdd_sync_t     (tdd_sync_t),
        .enable         (enable),
        .txnrx          (txnrx),
        .frame_cnt      (frame_cnt),
        .busy           (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic sync_ext, input logic [NUM_DEV-1:0] mask,
                       input int len, input int rxon, input int rxoff,
                       input int txon, input int txoff);
        ctrl_sync_ext  = sync_ext;
        ctrl_dev_mask  = mask;
        ctrl_frame_len = CNT_WIDTH'(len);
        ctrl_rx_on     = CNT_WIDTH'(rxon);
        ctrl_rx_off    = CNT_WIDTH'(rxoff);
        ctrl_tx_on     = CNT_WIDTH'(txon);
        ctrl_tx_off    = CNT_WIDTH'(txoff);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ctrl_en = 1'b0;
        tdd_sync_i = 1'b0;
        cfg(1'b0, '0, 0, 0, 0, 0, 0);
        step();
        step();
        n_checks += 6;
        if (frame_cnt !== '0) begin n_fail++; $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt); end
        if (enable !== '0) begin n_fail++; $display("FAIL reset_enable got=%b exp=00", enable); end
        if (txnrx !== '0) begin n_fail++; $display("FAIL reset_txnrx got=%b exp=00", txnrx); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (tdd_sync_o !== 1'b0) begin n_fail++; $display("FAIL reset_sync_o got=%b exp=0", tdd_sync_o); end
        if (tdd_sync_t !== 1'b1) begin n_fail++; $display("FAIL reset_sync_t got=%b exp=1", tdd_sync_t); end
        rst = 1'b0;
        step();
    endtask

    // Master run of 256 cycles, then ctrl_en dropped at frame_cnt=55 (tx window).
    task automatic test_master_windows();
        exp_t                 e;
        logic [CNT_WIDTH-1:0] c;
        logic                 rx_w;
        logic                 tx_w;
        cfg(1'b0, 2'b11, 99, 10, 40, 50, 90);
        exp_q.delete();
        exp_q.push_back('0);
        ctrl_en = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            step();
            c = CNT_WIDTH'((k - 1) % 100);
            e = exp_q.pop_front();
            n_checks += 6;
            if (frame_cnt !== c) begin n_fail++; $display("FAIL master_cnt k=%0d got=%0d exp=%0d", k, frame_cnt, c); end
            if (busy !== 1'b1) begin n_fail++; $display("FAIL master_busy k=%0d got=%b exp=1", k, busy); end
            if (enable !== e.en) begin n_fail++; $display("FAIL master_enable k=%0d got=%b exp=%b", k, enable, e.en); end
            if (txnrx !== e.tx) begin n_fail++; $display("FAIL master_txnrx k=%0d got=%b exp=%b", k, txnrx, e.tx); end
            if (tdd_sync_o !== e.so) begin n_fail++; $display("FAIL master_sync_o k=%0d got=%b exp=%b", k, tdd_sync_o, e.so); end
            if (tdd_sync_t !== !SYNC_EN) begin n_fail++; $display("FAIL master_sync_t k=%0d got=%b exp=%b", k, tdd_sync_t, !SYNC_EN); end
            rx_w = (c >= 10) && (c < 40);
            tx_w = (c >= 50) && (c < 90);
            e.en = (rx_w || tx_w) ? 2'b11 : 2'b00;
            e.tx = tx_w ? 2'b11 : 2'b00;
            e.so = SYNC_EN && (c < 4);
            exp_q.push_back(e);
            if (k == 120) ctrl_rx_on = CNT_WIDTH'(0);
        end
        ctrl_en = 1'b0;
        step();
        n_checks += 5;
        if (frame_cnt !== '0) begin n_fail++; $display("FAIL drop_cnt got=%0d exp=0", frame_cnt); end
        if (enable !== '0) begin n_fail++; $display("FAIL drop_enable got=%b exp=00", enable); end
        if (txnrx !== '0) begin n_fail++; $display("FAIL drop_txnrx got=%b exp=00", txnrx); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_busy got=%b exp=0", busy); end
        if (tdd_sync_o !== 1'b0) begin n_fail++; $display("FAIL drop_sync_o got=%b exp=0", tdd_sync_o); end
    endtask

    // Slave: sync sampled at edge 20 -> RUN at 23; second edge at 61 -> cnt 0 at 64.
    task automatic test_slave_resync();
        exp_t                 e;
        logic [CNT_WIDTH-1:0] c;
        cfg(1'b1, 2'b01, 99, 0, 50, 0, 0);
        tdd_sync_i = 1'b0;
        exp_q.delete();
        exp_q.push_back('0);
        ctrl_en = 1'b1;
        for (int s = 1; s <= 70; s++) begin
            step();
            if (s < 23)      c = '0;
            else if (s < 64) c = CNT_WIDTH'(s - 23);
            else             c = CNT_WIDTH'(s - 64);
            e = exp_q.pop_front();
            n_checks += 6;
            if (frame_cnt !== c) begin n_fail++; $display("FAIL slave_cnt s=%0d got=%0d exp=%0d", s, frame_cnt, c); end
            if (busy !== 1'b1) begin n_fail++; $display("FAIL slave_busy s=%0d got=%b exp=1", s, busy); end
            if (enable !== e.en) begin n_fail++; $display("FAIL slave_enable s=%0d got=%b exp=%b", s, enable, e.en); end
            if (txnrx !== e.tx) begin n_fail++; $display("FAIL slave_txnrx s=%0d got=%b exp=%b", s, txnrx, e.tx); end
            if (tdd_sync_o !== 1'b0) begin n_fail++; $display("FAIL slave_sync_o s=%0d got=%b exp=0", s, tdd_sync_o); end
            if (tdd_sync_t !== 1'b1) begin n_fail++; $display("FAIL slave_sync_t s=%0d got=%b exp=1", s, tdd_sync_t); end
            e.en = ((s >= 23) && (c < 50)) ? 2'b01 : 2'b00;
            e.tx = 2'b00;
            e.so = 1'b0;
            exp_q.push_back(e);
            if (s == 19 || s == 60) tdd_sync_i = 1'b1;
            if (s == 25 || s == 66) tdd_sync_i = 1'b0;
        end
        ctrl_en = 1'b0;
        step();
        n_checks += 2;
        if (frame_cnt !== '0) begin n_fail++; $display("FAIL slave_drop_cnt got=%0d exp=0", frame_cnt); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL slave_drop_busy got=%b exp=0", busy); end
    endtask

    task automatic test_empty_windows();
        cfg(1'b0, 2'b11, 99, 30, 30, 60, 20);
        ctrl_en = 1'b1;
        for (int k = 1; k <= 120; k++) begin
            step();
            n_checks += 3;
            if (frame_cnt !== CNT_WIDTH'((k - 1) % 100)) begin n_fail++; $display("FAIL empty_cnt k=%0d got=%0d exp=%0d", k, frame_cnt, (k - 1) % 100); end
            if (enable !== '0) begin n_fail++; $display("FAIL empty_enable k=%0d got=%b exp=00", k, enable); end
            if (txnrx !== '0) begin n_fail++; $display("FAIL empty_txnrx k=%0d got=%b exp=00", k, txnrx); end
        end
        ctrl_en = 1'b0;
        step();
    endtask

    task automatic test_frame_len_zero();
        logic [NUM_DEV-1:0] exp_en;
        cfg(1'b0, 2'b10, 0, 0, 1, 5, 6);
        ctrl_en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_en = (k >= 2) ? 2'b10 : 2'b00;
            n_checks += 3;
            if (frame_cnt !== '0) begin n_fail++; $display("FAIL len0_cnt k=%0d got=%0d exp=0", k, frame_cnt); end
            if (enable !== exp_en) begin n_fail++; $display("FAIL len0_enable k=%0d got=%b exp=%b", k, enable, exp_en); end
            if (txnrx !== '0) begin n_fail++; $display("FAIL len0_txnrx k=%0d got=%b exp=00", k, txnrx); end
        end
        ctrl_en = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_run();
        cfg(1'b0, 2'b11, 99, 10, 40, 50, 90);
        ctrl_en = 1'b1;
        for (int k = 1; k <= 71; k++) step();
        n_checks += 2;
        if (frame_cnt !== CNT_WIDTH'(70)) begin n_fail++; $display("FAIL midrst_pre_cnt got=%0d exp=70", frame_cnt); end
        if (txnrx !== 2'b11) begin n_fail++; $display("FAIL midrst_pre_txnrx got=%b exp=11", txnrx); end
        rst = 1'b1;
        step();
        n_checks += 6;
        if (frame_cnt !== '0) begin n_fail++; $display("FAIL midrst_cnt got=%0d exp=0", frame_cnt); end
        if (enable !== '0) begin n_fail++; $display("FAIL midrst_enable got=%b exp=00", enable); end
        if (txnrx !== '0) begin n_fail++; $display("FAIL midrst_txnrx got=%b exp=00", txnrx); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        if (tdd_sync_o !== 1'b0) begin n_fail++; $display("FAIL midrst_sync_o got=%b exp=0", tdd_sync_o); end
        if (tdd_sync_t !== 1'b1) begin n_fail++; $display("FAIL midrst_sync_t got=%b exp=1", tdd_sync_t); end
        ctrl_en = 1'b0;
        rst = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_master_windows();
        test_slave_resync();
        test_empty_windows();
        test_frame_len_zero();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
